// File: rtl/z_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : z_skid_buf
//  Purpose  : Two-entry skid buffer for a producer result word. in_ready and
//             out_valid come from state registers only, so neither handshake
//             has a combinational path through the buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module z_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    // The consumer always sees the oldest entry, held in main.
    assign out_data = main_q;

    // State and storage registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state and storage update; flush discards both entries and any
    // word offered in the same cycle.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = S_TWO;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only the drain case applies.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // Handshake and occupancy outputs decoded from the state register alone.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
        case (state_q)
            S_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
            S_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                count     = 2'd1;
            end
            S_TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_z_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_z_skid_buf
//  Purpose  : Scoreboard bench for z_skid_buf. A queue models the buffer
//             contents; the monitor compares every delivered word and the
//             handshake/occupancy outputs against it each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_z_skid_buf;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [1:0]    count;

    z_skid_buf #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words accepted but not yet delivered, oldest first,
    // plus the value out_data must show while nothing is buffered.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_word;
    logic         mon_en;
    int           n_total;
    int           n_pass;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Monitor: shortly after inputs settle, compare outputs with the model
    // and retire the front word whenever the consumer takes it.
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            check("count", {30'd0, count}, W'(exp_q.size()));
            check("out_valid", {31'd0, out_valid}, W'(exp_q.size() != 0));
            check("in_ready", {31'd0, in_ready}, W'(exp_q.size() < 2));
            if (exp_q.size() == 0) check("idle_out_data", out_data, last_word);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("underflow_out_valid", {31'd0, out_valid}, '0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    last_word = exp_q.pop_front();
                end
            end
        end
    end

    // One clock of stimulus; bookkeeping runs after the monitor has looked.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                        input logic fl, input logic rs);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        #2;
        if (rs || fl) begin
            exp_q.delete();
            last_word = '0;
        end else if (iv && in_ready) begin
            exp_q.push_back(id);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0; n_pass = 0; mon_en = 1'b0; last_word = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("rst_count", {30'd0, count}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'd0);

        // Single word, one-cycle latency
        step(1, 32'h0000_00A5, 0, 0, 0);
        @(posedge clk); #1;
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_data", out_data, 32'h0000_00A5);
        check("lat_count", {30'd0, count}, 32'd1);
        check("lat_in_ready", {31'd0, in_ready}, 32'd1);
        step(0, 0, 1, 0, 0);

        // Fill to two, then drain in order
        step(1, 32'h11, 0, 0, 0);
        step(1, 32'h22, 0, 0, 0);
        @(posedge clk); #1;
        check("full_count", {30'd0, count}, 32'd2);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_head", out_data, 32'h11);
        step(0, 0, 1, 0, 0);
        @(posedge clk); #1;
        check("drain_second", out_data, 32'h22);
        step(0, 0, 1, 0, 0);
        @(posedge clk); #1;
        check("drain_count", {30'd0, count}, 32'd0);

        // Streaming at full rate never needs the skid entry
        for (int i = 1; i <= 8; i++) begin
            step(1, W'(i), 1, 0, 0);
            @(posedge clk); #1;
            check("stream_count_le1", {31'd0, count <= 2'd1}, 32'd1);
            check("stream_head", out_data, W'(i));
        end
        step(0, 0, 1, 0, 0);

        // Flush in TWO together with an offered word
        step(1, 32'h66, 0, 0, 0);
        step(1, 32'h77, 0, 0, 0);
        step(1, 32'h33, 0, 1, 0);
        @(posedge clk); #1;
        check("flush_count", {30'd0, count}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_out_data", out_data, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        // Reset in ONE together with an accepted word
        step(1, 32'h44, 0, 0, 0);
        step(1, 32'h55, 0, 0, 1);
        @(posedge clk); #1;
        check("mrst_count", {30'd0, count}, 32'd0);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_data", out_data, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            logic rs;
            logic fl;
            rs = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 49) == 0);
            step(1'($urandom), $urandom, rs ? 1'b0 : 1'($urandom), fl, rs);
        end

        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
